// File: rtl/vdma_frame_scheduler.sv
// Triple-buffer frame scheduler for a vdma_compact_port_verb instance: rotates write/read
// buffer indices on vsync edges so the reader never touches the frame being written.
module vdma_frame_scheduler #(
    parameter int              ASIZE      = 29,
    parameter int              FRAME_NUM  = 3,
    parameter logic [ASIZE-1:0] FRAME_SIZE = 29'h0080_0000,
    parameter logic [ASIZE-1:0] BASEADDR   = 29'h0,
    parameter logic            VS_POL     = 1'b1,
    parameter int              CSIZE      = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             cfg_enable,
    input  logic             cnt_clr,
    input  logic             wr_vsync,
    input  logic             rd_vsync,
    output logic [ASIZE-1:0] wr_baseaddr,
    output logic [ASIZE-1:0] rd_baseaddr,
    output logic             trs_enable,
    output logic             rev_enable,
    output logic [2:0]       wr_idx,
    output logic [2:0]       rd_idx,
    output logic [1:0]       state,
    output logic [CSIZE-1:0] wr_frame_cnt,
    output logic [CSIZE-1:0] drop_cnt,
    output logic [CSIZE-1:0] repeat_cnt
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;

    localparam logic [2:0] RD_IDX_INIT = 3'(FRAME_NUM - 1);

    // Constant base-address table; unused entries beyond FRAME_NUM are never selected.
    logic [ASIZE-1:0] addr_tab [8];
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_addr
            assign addr_tab[gi] = BASEADDR + FRAME_SIZE * ASIZE'(gi);
        end
    endgenerate

    logic             wr_vs_q, wr_vs_d;
    logic             rd_vs_q, rd_vs_d;
    logic [1:0]       state_q, state_d;
    logic [2:0]       wr_idx_q, wr_idx_d;
    logic [2:0]       rd_idx_q, rd_idx_d;
    logic [2:0]       latest_q, latest_d;
    logic             fresh_q, fresh_d;
    logic             wr_active_q, wr_active_d;
    logic             trs_q, trs_d;
    logic             rev_q, rev_d;
    logic [ASIZE-1:0] wr_base_q, wr_base_d;
    logic [ASIZE-1:0] rd_base_q, rd_base_d;
    logic [CSIZE-1:0] wr_cnt_q, wr_cnt_d;
    logic [CSIZE-1:0] drop_cnt_q, drop_cnt_d;
    logic [CSIZE-1:0] rep_cnt_q, rep_cnt_d;

    logic       wfs, rfs;
    logic       inc_wr, inc_drop, inc_rep;
    logic [2:0] done;

    assign wfs = (wr_vsync == VS_POL) && (wr_vs_q != VS_POL);
    assign rfs = (rd_vsync == VS_POL) && (rd_vs_q != VS_POL);

    // First buffer after 'base' (cyclically) that is neither 'base' nor 'avoid'.
    function automatic logic [2:0] next_wr(input logic [2:0] base, input logic [2:0] avoid);
        logic [2:0] cand;
        logic [2:0] pick;
        logic       found;
        pick  = base;
        found = 1'b0;
        for (int k = 1; k < FRAME_NUM; k++) begin
            cand = 3'((int'(base) + k) % FRAME_NUM);
            if (!found && (cand != avoid) && (cand != base)) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        wr_vs_d     = wr_vsync;
        rd_vs_d     = rd_vsync;
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        latest_d    = latest_q;
        fresh_d     = fresh_q;
        wr_active_d = wr_active_q;
        inc_wr      = 1'b0;
        inc_drop    = 1'b0;
        inc_rep     = 1'b0;
        done        = wr_idx_q;

        if (!cfg_enable) begin
            state_d     = ST_IDLE;
            wr_idx_d    = 3'd0;
            rd_idx_d    = RD_IDX_INIT;
            latest_d    = 3'd0;
            fresh_d     = 1'b0;
            wr_active_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_WAIT;
                ST_WAIT: begin
                    // The first vsync only marks the start of a complete frame.
                    if (wfs) begin
                        if (!wr_active_q) begin
                            wr_active_d = 1'b1;
                        end else begin
                            latest_d = 3'd0;
                            rd_idx_d = 3'd0;
                            wr_idx_d = 3'd1;
                            fresh_d  = 1'b0;
                            inc_wr   = 1'b1;
                            state_d  = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (wfs) begin
                        inc_wr   = 1'b1;
                        inc_drop = fresh_q && !rfs;
                        latest_d = done;
                        fresh_d  = 1'b1;
                        if (rfs) begin
                            rd_idx_d = done;
                            fresh_d  = 1'b0;
                        end
                        wr_idx_d = next_wr(done, rd_idx_d);
                    end else if (rfs) begin
                        if (fresh_q) begin
                            rd_idx_d = latest_q;
                            fresh_d  = 1'b0;
                        end else begin
                            inc_rep = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    wr_idx_d = 3'd0;
                    rd_idx_d = RD_IDX_INIT;
                end
            endcase
        end

        trs_d     = (state_d != ST_IDLE);
        rev_d     = cfg_enable && (state_q == ST_RUN);
        wr_base_d = addr_tab[wr_idx_q];
        rd_base_d = addr_tab[rd_idx_q];

        if (cnt_clr) begin
            wr_cnt_d   = '0;
            drop_cnt_d = '0;
            rep_cnt_d  = '0;
        end else begin
            wr_cnt_d   = wr_cnt_q   + (inc_wr   ? CSIZE'(1) : CSIZE'(0));
            drop_cnt_d = drop_cnt_q + (inc_drop ? CSIZE'(1) : CSIZE'(0));
            rep_cnt_d  = rep_cnt_q  + (inc_rep  ? CSIZE'(1) : CSIZE'(0));
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_vs_q     <= ~VS_POL;
            rd_vs_q     <= ~VS_POL;
            state_q     <= ST_IDLE;
            wr_idx_q    <= 3'd0;
            rd_idx_q    <= RD_IDX_INIT;
            latest_q    <= 3'd0;
            fresh_q     <= 1'b0;
            wr_active_q <= 1'b0;
            trs_q       <= 1'b0;
            rev_q       <= 1'b0;
            wr_base_q   <= addr_tab[0];
            rd_base_q   <= addr_tab[RD_IDX_INIT];
            wr_cnt_q    <= '0;
            drop_cnt_q  <= '0;
            rep_cnt_q   <= '0;
        end else begin
            wr_vs_q     <= wr_vs_d;
            rd_vs_q     <= rd_vs_d;
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            latest_q    <= latest_d;
            fresh_q     <= fresh_d;
            wr_active_q <= wr_active_d;
            trs_q       <= trs_d;
            rev_q       <= rev_d;
            wr_base_q   <= wr_base_d;
            rd_base_q   <= rd_base_d;
            wr_cnt_q    <= wr_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end

    assign wr_baseaddr  = wr_base_q;
    assign rd_baseaddr  = rd_base_q;
    assign trs_enable   = trs_q;
    assign rev_enable   = rev_q;
    assign wr_idx       = wr_idx_q;
    assign rd_idx       = rd_idx_q;
    assign state        = state_q;
    assign wr_frame_cnt = wr_cnt_q;
    assign drop_cnt     = drop_cnt_q;
    assign repeat_cnt   = rep_cnt_q;

endmodule

// File: doc/vdma_frame_scheduler.md
Name: vdma_frame_scheduler

Overview:
- Triple-buffer frame scheduler that sequences one vdma_compact_port_verb instance.
- Tracks the write and read frame boundaries and rotates buffer indices so the reader never reads the frame the writer is filling.
- Drives wr_baseaddr, rd_baseaddr, trs_enable and rev_enable into the port, and exposes drop and repeat statistics.
- Sits in the AXI clock domain; vsync inputs are already synchronised to clock upstream.

Parameters:
ASIZE, 29, address width (matches port ASIZE)
FRAME_NUM, 3, number of frame buffers; legal range 3..8
FRAME_SIZE, 29'h0080_0000, byte stride between buffers
BASEADDR, 29'h0, address of buffer 0
VS_POL, 1, active level of wr_vsync/rd_vsync
CSIZE, 16, statistics counter width

Ports:
clock  in  1  single clock, all logic on rising edge
rst  in  1  synchronous reset, active high
cfg_enable  in  1  scheduler run enable
cnt_clr  in  1  synchronous clear of statistics counters
wr_vsync  in  1  input-video vsync (port vin side)
rd_vsync  in  1  output-video vsync (port vex/vout side)
wr_baseaddr  out  ASIZE  frame base address to writer
rd_baseaddr  out  ASIZE  frame base address to reader
trs_enable  out  1  writer enable
rev_enable  out  1  reader enable
wr_idx  out  3  current write buffer index
rd_idx  out  3  current read buffer index
state  out  2  00 IDLE, 01 WAIT_FIRST, 10 RUN
wr_frame_cnt  out  CSIZE  completed write frames
drop_cnt  out  CSIZE  completed frames never read
repeat_cnt  out  CSIZE  read frames that reused the previous buffer

Behaviour:
- Frame start detection:
  - wfs = (wr_vsync==VS_POL) && !(wr_vs_d==VS_POL), where wr_vs_d is a 1-cycle register of wr_vsync; rfs is formed likewise.
  - All index and state updates occur on the edge where wfs/rfs is true.
  - wr_baseaddr/rd_baseaddr are registered from the indices, so they change one edge later.
  - Address = BASEADDR + idx*FRAME_SIZE, truncated to ASIZE.
- Reset (rst=1): state=IDLE, wr_idx=0, rd_idx=FRAME_NUM-1, wr_active=0, fresh=0, latest=0, enables=0, addresses from those indices, all counters=0, vsync history registers=inactive.
- IDLE: both enables 0. On cfg_enable=1 → WAIT_FIRST; trs_enable=1 from the next edge.
- WAIT_FIRST:
  - First wfs sets wr_active=1; no frame completes.
  - Second wfs completes buffer 0: latest=0, rd_idx=0, wr_idx=1, wr_frame_cnt+1 → RUN.
  - rev_enable=1 from the next edge.
  - rfs is ignored in this state.
- RUN, wfs only:
  - done=wr_idx; if fresh was already 1, drop_cnt+1.
  - latest=done, fresh=1, wr_frame_cnt+1.
  - wr_idx = first (wr_idx+k) mod FRAME_NUM, k=1..FRAME_NUM-1, that is ≠ rd_idx and ≠ done.
- RUN, rfs only:
  - fresh=1: rd_idx=latest, fresh=0.
  - fresh=0: rd_idx unchanged, repeat_cnt+1.
- RUN, wfs and rfs in the same cycle:
  - Writer completion is resolved first; the reader takes the just-completed buffer (rd_idx=done, fresh=0, no repeat).
  - New wr_idx is chosen to avoid the new rd_idx and done.
- Invariant: wr_idx ≠ rd_idx in WAIT_FIRST and RUN at all times. The bench asserts this.
- cfg_enable=0 in any state: next edge → IDLE with enables 0 and indices/fresh/wr_active reset as at rst. Counters hold.
- cnt_clr: zeroes all counters on that edge and has priority over increments in the same cycle.
- Counters wrap modulo 2^CSIZE.
- Mid-frame cfg_enable drop then re-assert restarts at WAIT_FIRST and discards the partial frame (no count).

Test Plan:
1. rst, cfg_enable=1, wr_vsync pulses ×2 → after 2nd pulse state=RUN, rd_idx=0, wr_idx=1, rd_baseaddr=0x0, wr_baseaddr=0x0080_0000, rev_enable=1 one edge later, wr_frame_cnt=1.
2. RUN, equal rates with rfs 100 cycles after each wfs, 10 frames → wr_idx/rd_idx rotate without collision, drop_cnt=0, repeat_cnt=0, wr_frame_cnt=11.
3. Writer at 2× reader rate for 20 write frames → drop_cnt≈10, repeat_cnt=0, wr_idx never equals rd_idx.
4. Reader at 2× writer rate → repeat_cnt increments on every other rfs, rd_idx held across repeats, drop_cnt=0.
5. wfs and rfs in the same cycle with wr_idx=1, rd_idx=0 → rd_idx=1, wr_idx=2, fresh=0, addresses update one edge later.
6. cfg_enable low mid-RUN for 1 cycle → IDLE, enables 0, wr_idx=0, rd_idx=2, counters retained. Then cnt_clr coincident with wfs → counters=0.
